// File: rtl/wishbone_to_l2_bridge.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_to_l2_bridge
// Purpose  : Wishbone classic slave -> single-word L2 requester, one beat in
//            flight. Optional read timeout enabled by macro WB_L2_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_to_l2_bridge #(
    parameter int SUB_ID         = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int L2_SUB_ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [29:0]            wb_adr,
    input  logic [31:0]            wb_dat_w,
    input  logic [3:0]             wb_sel,
    input  logic                   wb_we,
    input  logic                   wb_cyc,
    input  logic                   wb_stb,
    input  logic [2:0]             wb_cti,
    input  logic [1:0]             wb_bte,
    output logic                   wb_ack,
    output logic                   wb_err,
    output logic [31:0]            wb_dat_r,
    output logic [29:0]            l2_addr,
    output logic [3:0]             l2_be,
    output logic                   l2_rnw,
    output logic                   l2_is_amo,
    output logic [4:0]             l2_amo_type_or_burst_size,
    output logic [L2_SUB_ID_W-1:0] l2_sub_id,
    output logic                   l2_request_push,
    input  logic                   l2_request_full,
    output logic [31:0]            l2_wr_data,
    output logic                   l2_wr_data_push,
    input  logic                   l2_data_full,
    input  logic [31:0]            l2_rd_data,
    input  logic                   l2_rd_data_valid,
    input  logic [L2_SUB_ID_W-1:0] l2_rd_sub_id,
    output logic                   l2_rd_data_ack
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_RESP    = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    localparam logic [L2_SUB_ID_W-1:0] C_SUB_ID = L2_SUB_ID_W'(SUB_ID);

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_adr;
    logic [31:0] r_dat_w;
    logic [3:0]  r_be;
    logic        r_we;
    logic [31:0] r_dat_r;
    logic        w_rd_match;
    logic        w_capture;
    logic        w_timeout;
    logic        w_unused;

    // Burst hints are meaningless here: every beat is a classic single word.
    assign w_unused = ^{wb_cti, wb_bte};

    assign w_rd_match = l2_rd_data_valid && (l2_rd_sub_id == C_SUB_ID);

    assign l2_addr                   = r_adr;
    assign l2_be                     = r_be;
    assign l2_rnw                    = ~r_we;
    assign l2_is_amo                 = 1'b0;
    assign l2_amo_type_or_burst_size = 5'd0;
    assign l2_sub_id                 = C_SUB_ID;
    assign l2_wr_data                = r_dat_w;
    assign wb_dat_r                  = r_dat_r;

    always_comb begin
        w_next          = r_state;
        l2_request_push = 1'b0;
        l2_wr_data_push = 1'b0;
        l2_rd_data_ack  = 1'b0;
        wb_ack          = 1'b0;
        w_capture       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wb_cyc && wb_stb) begin
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Writes need room in both queues so request and data stay paired.
                if (!l2_request_full && (!r_we || !l2_data_full)) begin
                    l2_request_push = 1'b1;
                    l2_wr_data_push = r_we;
                    w_next          = r_we ? S_RESP : S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (w_rd_match) begin
                    l2_rd_data_ack = 1'b1;
                    w_capture      = 1'b1;
                    w_next         = S_RESP;
                end else if (w_timeout || !wb_cyc) begin
                    w_next = S_DRAIN;
                end
            end
            S_RESP: begin
                wb_ack = wb_cyc;
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (w_rd_match) begin
                    l2_rd_data_ack = 1'b1;
                    w_next         = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_adr   <= 30'd0;
            r_dat_w <= 32'd0;
            r_be    <= 4'd0;
            r_we    <= 1'b0;
            r_dat_r <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && wb_cyc && wb_stb) begin
                r_adr   <= wb_adr;
                r_dat_w <= wb_dat_w;
                r_we    <= wb_we;
                r_be    <= wb_we ? wb_sel : 4'hF;
            end
            if (w_capture) begin
                r_dat_r <= l2_rd_data;
            end else if (w_timeout) begin
                r_dat_r <= 32'hDEADBEEF;
            end
        end
    end

`ifdef WB_L2_TIMEOUT_EN
    localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [C_CNT_W-1:0] r_cnt;
    logic               r_err;

    assign w_timeout = (r_state == S_WAIT_RD) && !w_rd_match
                       && (r_cnt == C_CNT_W'(TIMEOUT_CYCLES - 1));
    assign wb_err    = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state == S_WAIT_RD && w_next == S_WAIT_RD) begin
                r_cnt <= r_cnt + C_CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    localparam int C_UNUSED_TIMEOUT = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
    assign wb_err    = 1'b0;
`endif

endmodule
`default_nettype wire
